// File: rtl/snn_pkg.sv
// Shared types for the SNN inference controller: FSM state encoding.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STEP   = 3'd2,
    WAIT   = 3'd3,
    DECIDE = 3'd4,
    AMWAIT = 3'd5,
    HOLD   = 3'd6
  } state_t;

endpackage

// File: rtl/snn_inference_ctrl.sv
// Sequences one SNN inference (clear, NUM_STEPS core steps, argmax); start->res_valid is 1+NUM_STEPS*(1+core)+2 cycles.
// Result held in HOLD until res_ready; start ignored while busy; a stalled core or argmax aborts with res_error.
module snn_inference_ctrl
  import snn_pkg::*;
#(
  parameter int NUM_STEPS   = 16,
  parameter int NUM_CLASSES = 3,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CLS_W = $clog2(NUM_CLASSES),
  localparam int SW    = $clog2(NUM_STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [SW-1:0]    step_idx,
  output logic             core_clear,
  output logic             core_step_req,
  input  logic             core_step_done,
  output logic             am_valid,
  input  logic             am_done,
  input  logic [CLS_W-1:0] am_class,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CLS_W-1:0] res_class,
  output logic             res_error
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0]   LAST_IDX = SW'(NUM_STEPS);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic [SW-1:0]   step_inc;
  logic            wd_expire;
  logic            do_latch;
  logic            do_abort;

  assign step_inc  = step_idx + SW'(1);
  // wd_cnt counts completed wait cycles, so TIMEOUT_CYC wait cycles elapse before abort
  assign wd_expire = (wd_cnt == WD_LIMIT);

  always_comb begin
    state_nxt     = state;
    busy          = 1'b1;
    core_clear    = 1'b0;
    core_step_req = 1'b0;
    am_valid      = 1'b0;
    res_valid     = 1'b0;
    do_latch      = 1'b0;
    do_abort      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        core_clear = 1'b1;
        state_nxt  = STEP;
      end
      STEP: begin
        core_step_req = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (core_step_done) begin
          state_nxt = (step_inc == LAST_IDX) ? DECIDE : STEP;
        end else if (wd_expire) begin
          do_abort  = 1'b1;
          state_nxt = HOLD;
        end
      end
      DECIDE: begin
        am_valid  = 1'b1;
        state_nxt = AMWAIT;
      end
      AMWAIT: begin
        if (am_done) begin
          do_latch  = 1'b1;
          state_nxt = HOLD;
        end else if (wd_expire) begin
          do_abort  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step_idx  <= '0;
      wd_cnt    <= '0;
      res_class <= '0;
      res_error <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == CLEAR) begin
        step_idx <= '0;
      end else if (state == WAIT && core_step_done) begin
        step_idx <= step_inc;
      end

      if (state == WAIT || state == AMWAIT) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end

      if (do_latch) begin
        res_class <= am_class;
        res_error <= 1'b0;
      end else if (do_abort) begin
        res_class <= '0;
        res_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Scoreboard bench for snn_inference_ctrl: instance A (4 steps, timeout 8), instance B (1 step, timeout 2).
`timescale 1ns/1ps
module tb_snn_inference_ctrl;

  localparam int NS_A = 4;
  localparam int TO_A = 8;
  localparam int NS_B = 1;
  localparam int TO_B = 2;
  localparam int NC   = 3;
  localparam int CW   = $clog2(NC);
  localparam int SWA  = $clog2(NS_A + 1);
  localparam int SWB  = $clog2(NS_B + 1);

  typedef struct packed {
    logic [CW-1:0] cls;
    logic          err;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a = 1'b0, start_a = 1'b0, res_ready_a = 1'b0;
  logic           busy_a, core_clear_a, core_step_req_a, core_step_done_a;
  logic           am_valid_a, am_done_a, res_valid_a, res_error_a;
  logic [SWA-1:0] step_idx_a;
  logic [CW-1:0]  am_class_a, res_class_a;

  logic           rst_b = 1'b0, start_b = 1'b0, res_ready_b = 1'b0;
  logic           busy_b, core_clear_b, core_step_req_b, core_step_done_b;
  logic           am_valid_b, am_done_b, res_valid_b, res_error_b;
  logic [SWB-1:0] step_idx_b;
  logic [CW-1:0]  am_class_b, res_class_b;

  snn_inference_ctrl #(.NUM_STEPS(NS_A), .NUM_CLASSES(NC), .TIMEOUT_CYC(TO_A)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .step_idx(step_idx_a),
    .core_clear(core_clear_a), .core_step_req(core_step_req_a), .core_step_done(core_step_done_a),
    .am_valid(am_valid_a), .am_done(am_done_a), .am_class(am_class_a),
    .res_valid(res_valid_a), .res_ready(res_ready_a), .res_class(res_class_a), .res_error(res_error_a)
  );

  snn_inference_ctrl #(.NUM_STEPS(NS_B), .NUM_CLASSES(NC), .TIMEOUT_CYC(TO_B)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .step_idx(step_idx_b),
    .core_clear(core_clear_b), .core_step_req(core_step_req_b), .core_step_done(core_step_done_b),
    .am_valid(am_valid_b), .am_done(am_done_b), .am_class(am_class_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b), .res_class(res_class_b), .res_error(res_error_b)
  );

  int checks = 0;
  int failures = 0;
  res_t exp_q_a[$];
  res_t exp_q_b[$];

  // Core/argmax model knobs: done arrives core_lat cycles after the req cycle
  int            core_lat_a = 3, hang_a = -1, core_lat_b = 2;
  logic [CW-1:0] am_pick_a = '0, am_pick_b = '0;
  int            n_clear_a = 0, n_req_a = 0, n_am_a = 0, n_fall_a = 0;
  logic          busy_prev_a = 1'b0;

  initial begin : model_a
    int cnt, req_no;
    bit am_pend;
    cnt = 0; req_no = 0; am_pend = 0;
    core_step_done_a = 1'b0; am_done_a = 1'b0; am_class_a = '0;
    forever begin
      @(negedge clk);
      core_step_done_a = 1'b0;
      am_done_a = 1'b0;
      am_class_a = CW'($urandom);
      if (rst_a) begin
        cnt = 0; req_no = 0; am_pend = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) core_step_done_a = 1'b1;
        end
        if (am_pend) begin
          am_done_a = 1'b1; am_class_a = am_pick_a; am_pend = 0;
        end
        if (core_clear_a) req_no = 0;
        if (core_step_req_a) begin
          if (req_no != hang_a) cnt = core_lat_a;
          req_no++;
        end
        if (am_valid_a) am_pend = 1;
      end
    end
  end

  initial begin : model_b
    int cnt;
    bit am_pend;
    cnt = 0; am_pend = 0;
    core_step_done_b = 1'b0; am_done_b = 1'b0; am_class_b = '0;
    forever begin
      @(negedge clk);
      core_step_done_b = 1'b0;
      am_done_b = 1'b0;
      am_class_b = CW'($urandom);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) core_step_done_b = 1'b1;
      end
      if (am_pend) begin
        am_done_b = 1'b1; am_class_b = am_pick_b; am_pend = 0;
      end
      if (core_step_req_b) cnt = core_lat_b;
      if (am_valid_b) am_pend = 1;
    end
  end

  initial begin : monitor_a
    forever begin
      @(negedge clk);
      if (core_clear_a) n_clear_a++;
      if (core_step_req_a) n_req_a++;
      if (am_valid_a) n_am_a++;
      if (busy_prev_a && !busy_a) n_fall_a++;
      busy_prev_a = busy_a;
    end
  end

  // Returns at the negedge after the accepting edge, i.e. inside CLEAR
  task automatic pulse_start(input bit b);
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_res(input bit b, input int budget, output int cyc, output bit seen);
    cyc = 0;
    seen = 0;
    while (cyc < budget) begin
      if (b ? res_valid_b : res_valid_a) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept(input bit b);
    if (b) res_ready_b = 1'b1; else res_ready_a = 1'b1;
    @(negedge clk);
    res_ready_a = 1'b0;
    res_ready_b = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    #1 rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    obs = 32'({busy_a, step_idx_a, core_clear_a, core_step_req_a, am_valid_a, res_valid_a, res_class_a, res_error_a});
    checks++;
    if (obs !== 32'd0) begin failures++; $display("FAIL reset_a: outputs=%h required=0", obs); end
    obs = 32'({busy_b, step_idx_b, core_clear_b, core_step_req_b, am_valid_b, res_valid_b, res_class_b, res_error_b});
    checks++;
    if (obs !== 32'd0) begin failures++; $display("FAIL reset_b: outputs=%h required=0", obs); end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int c_clr, c_req, c_am, cyc;
    bit seen;
    res_t e;
    c_clr = n_clear_a; c_req = n_req_a; c_am = n_am_a;
    core_lat_a = 3; hang_a = -1; am_pick_a = CW'(2);
    exp_q_a.push_back('{cls: CW'(2), err: 1'b0});
    pulse_start(0);
    wait_res(0, 200, cyc, seen);
    e = exp_q_a.pop_front();
    checks++;
    if (!seen) begin failures++; $display("FAIL basic_res_valid: not seen within %0d cycles", cyc); end
    checks++;
    if (cyc != 1 + NS_A * (1 + 3) + 2) begin failures++; $display("FAIL basic_latency: got %0d required %0d", cyc, 1 + NS_A * 4 + 2); end
    checks++;
    if (res_class_a !== e.cls || res_error_a !== e.err) begin
      failures++; $display("FAIL basic_result: class=%0d err=%0d required class=%0d err=%0d", res_class_a, res_error_a, e.cls, e.err);
    end
    checks++;
    if (n_req_a - c_req != NS_A) begin failures++; $display("FAIL basic_step_req_count: got %0d required %0d", n_req_a - c_req, NS_A); end
    checks++;
    if (n_clear_a - c_clr != 1 || n_am_a - c_am != 1) begin
      failures++; $display("FAIL basic_clear_am_count: clear=%0d am=%0d required 1 and 1", n_clear_a - c_clr, n_am_a - c_am);
    end
    accept(0);
    checks++;
    if (busy_a !== 1'b0 || res_valid_a !== 1'b0) begin failures++; $display("FAIL basic_idle: busy=%0d res_valid=%0d required 0 0", busy_a, res_valid_a); end
  endtask

  task automatic test_hold_stall();
    int cyc;
    bit seen, stable;
    res_t e;
    am_pick_a = CW'(1);
    exp_q_a.push_back('{cls: CW'(1), err: 1'b0});
    pulse_start(0);
    wait_res(0, 200, cyc, seen);
    e = exp_q_a.pop_front();
    stable = seen;
    repeat (10) begin
      @(negedge clk);
      if (res_valid_a !== 1'b1 || res_class_a !== e.cls || res_error_a !== e.err) stable = 0;
    end
    checks++;
    if (!stable) begin failures++; $display("FAIL hold_stable: res_valid=%0d class=%0d required 1 class=%0d", res_valid_a, res_class_a, e.cls); end
    accept(0);
    checks++;
    if (busy_a !== 1'b0 || res_valid_a !== 1'b0) begin failures++; $display("FAIL hold_release: busy=%0d res_valid=%0d required 0 0", busy_a, res_valid_a); end
    checks++;
    if (res_class_a !== e.cls) begin failures++; $display("FAIL hold_class_kept: got %0d required %0d", res_class_a, e.cls); end
  endtask

  task automatic test_timeout();
    int cyc;
    bit seen;
    res_t e;
    hang_a = 2;
    exp_q_a.push_back('{cls: CW'(0), err: 1'b1});
    pulse_start(0);
    wait_res(0, 200, cyc, seen);
    e = exp_q_a.pop_front();
    checks++;
    if (!seen || cyc != 1 + 2 * (1 + 3) + 1 + TO_A) begin
      failures++; $display("FAIL timeout_latency: seen=%0d got %0d required %0d", seen, cyc, 1 + 8 + 1 + TO_A);
    end
    checks++;
    if (res_error_a !== e.err || res_class_a !== e.cls) begin
      failures++; $display("FAIL timeout_result: err=%0d class=%0d required err=%0d class=%0d", res_error_a, res_class_a, e.err, e.cls);
    end
    checks++;
    if (step_idx_a !== SWA'(2)) begin failures++; $display("FAIL timeout_step_idx: got %0d required 2", step_idx_a); end
    accept(0);
    hang_a = -1;
  endtask

  task automatic test_back_to_back();
    int c_clr, c_fall, cyc;
    bit seen;
    res_t e;
    am_pick_a = CW'(2);
    exp_q_a.push_back('{cls: CW'(2), err: 1'b0});
    c_clr = n_clear_a; c_fall = n_fall_a;
    pulse_start(0);
    repeat (3) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_res(0, 200, cyc, seen);
    e = exp_q_a.pop_front();
    checks++;
    if (!seen || res_class_a !== e.cls || res_error_a !== e.err) begin
      failures++; $display("FAIL b2b_result: seen=%0d class=%0d err=%0d required class=%0d err=%0d", seen, res_class_a, res_error_a, e.cls, e.err);
    end
    res_ready_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    res_ready_a = 1'b0; start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_handshake_start: busy=%0d required 0", busy_a); end
    repeat (30) @(negedge clk);
    checks++;
    if (n_clear_a - c_clr != 1 || n_fall_a - c_fall != 1 || busy_a !== 1'b0) begin
      failures++; $display("FAIL b2b_single_run: clears=%0d busy_falls=%0d busy=%0d required 1 1 0", n_clear_a - c_clr, n_fall_a - c_fall, busy_a);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, c_req;
    bit seen;
    logic [31:0] obs;
    res_t e;
    pulse_start(0);
    cyc = 0;
    while (cyc < 100 && !(busy_a && !core_step_req_a && step_idx_a == SWA'(3))) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc >= 100) begin failures++; $display("FAIL midrun_reach_step3: step_idx=%0d after %0d cycles", step_idx_a, cyc); end
    rst_a = 1'b1;
    @(negedge clk);
    obs = 32'({busy_a, step_idx_a, core_clear_a, core_step_req_a, am_valid_a, res_valid_a, res_class_a, res_error_a});
    checks++;
    if (obs !== 32'd0) begin failures++; $display("FAIL midrun_reset_outputs: outputs=%h required=0", obs); end
    rst_a = 1'b0;
    @(negedge clk);
    am_pick_a = CW'(1);
    exp_q_a.push_back('{cls: CW'(1), err: 1'b0});
    c_req = n_req_a;
    pulse_start(0);
    cyc = 0;
    while (cyc < 10 && !core_step_req_a) begin @(negedge clk); cyc++; end
    checks++;
    if (!core_step_req_a || step_idx_a !== '0) begin failures++; $display("FAIL midrun_restart_step0: req=%0d step_idx=%0d required 1 0", core_step_req_a, step_idx_a); end
    wait_res(0, 200, cyc, seen);
    e = exp_q_a.pop_front();
    checks++;
    if (!seen || res_class_a !== e.cls || res_error_a !== e.err || n_req_a - c_req != NS_A) begin
      failures++; $display("FAIL midrun_rerun: seen=%0d class=%0d err=%0d reqs=%0d required class=%0d err=%0d reqs=%0d",
                           seen, res_class_a, res_error_a, n_req_a - c_req, e.cls, e.err, NS_A);
    end
    accept(0);
  endtask

  task automatic test_limit_done();
    int cyc;
    bit seen;
    res_t e;
    core_lat_b = TO_B;
    am_pick_b = CW'(2);
    exp_q_b.push_back('{cls: CW'(2), err: 1'b0});
    pulse_start(1);
    wait_res(1, 100, cyc, seen);
    e = exp_q_b.pop_front();
    checks++;
    if (!seen || cyc != 1 + NS_B * (1 + TO_B) + 2) begin failures++; $display("FAIL limit_latency: seen=%0d got %0d required %0d", seen, cyc, 1 + NS_B * 3 + 2); end
    checks++;
    if (res_class_b !== e.cls || res_error_b !== e.err) begin
      failures++; $display("FAIL limit_done_wins: class=%0d err=%0d required class=%0d err=%0d", res_class_b, res_error_b, e.cls, e.err);
    end
    accept(1);
    core_lat_b = TO_B + 1;
    exp_q_b.push_back('{cls: CW'(0), err: 1'b1});
    pulse_start(1);
    wait_res(1, 100, cyc, seen);
    e = exp_q_b.pop_front();
    checks++;
    if (!seen || cyc != 1 + 1 + TO_B) begin failures++; $display("FAIL limit_abort_latency: seen=%0d got %0d required %0d", seen, cyc, 2 + TO_B); end
    checks++;
    if (res_class_b !== e.cls || res_error_b !== e.err || step_idx_b !== '0) begin
      failures++; $display("FAIL limit_abort: class=%0d err=%0d step=%0d required class=%0d err=%0d step=0", res_class_b, res_error_b, step_idx_b, e.cls, e.err);
    end
    accept(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_timeout();
    test_back_to_back();
    test_reset_midrun();
    test_limit_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

endmodule
